// File: rtl/step_ctrl.sv
`default_nettype none
// step_ctrl -- front-panel conditioner: synchronised, debounced switches and STEP button,
// plus a run/single-step CPU clock enable with auto-repeat. Rev 1.0
module step_ctrl #(
  parameter int DEBOUNCE_CNT = 50000,
  parameter int REPEAT_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switchs_raw,
  input  logic        btn_step_raw,
  output logic [15:0] switchs,
  output logic        step_pulse,
  output logic        cpu_clk_en,
  output logic [31:0] step_count
);

  localparam int TW = $clog2(DEBOUNCE_CNT);
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam int NB = 17;
  localparam logic [TW-1:0] TMAX = TW'(DEBOUNCE_CNT - 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } st_t;

  logic [NB-1:0] raw_all;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          btn;
  st_t           st;
  st_t           st_nx;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nx;
  logic          pulse_nx;
  logic [15:0]   step_cnt;

  // Button rides along as bit 16 so it shares the switch conditioning path.
  assign raw_all = {btn_step_raw, switchs_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tcnt == TMAX) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tick = (tcnt == TMAX);

  generate
    for (genvar i = 0; i < NB; i++) begin : g_deb
      logic [1:0] hist;
      logic       q;

      // Output moves only when three consecutive tick samples agree.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hist <= '0;
          q    <= 1'b0;
        end else if (tick) begin
          hist <= {hist[0], sync2[i]};
          if ({hist, sync2[i]} == 3'b111) begin
            q <= 1'b1;
          end else if ({hist, sync2[i]} == 3'b000) begin
            q <= 1'b0;
          end
        end
      end

      assign deb[i] = q;
    end
  endgenerate

  assign switchs = deb[15:0];
  assign btn     = deb[16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      rcnt       <= '0;
      step_pulse <= 1'b0;
    end else begin
      st         <= st_nx;
      rcnt       <= rcnt_nx;
      step_pulse <= pulse_nx;
    end
  end

  always_comb begin
    st_nx    = st;
    rcnt_nx  = rcnt;
    pulse_nx = 1'b0;
    case (st)
      ST_IDLE: begin
        if (btn) begin
          pulse_nx = 1'b1;
          rcnt_nx  = '0;
          st_nx    = ST_HELD;
        end
      end
      ST_HELD, ST_REPEAT: begin
        // Release wins over a repeat falling in the same cycle.
        if (!btn) begin
          st_nx = ST_IDLE;
        end else if (tick) begin
          if (rcnt == RMAX) begin
            pulse_nx = 1'b1;
            rcnt_nx  = '0;
            st_nx    = ST_REPEAT;
          end else begin
            rcnt_nx = rcnt + RW'(1);
          end
        end
      end
      default: begin
        st_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (step_pulse) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

  assign step_count = {16'd0, step_cnt};
  assign cpu_clk_en = switchs[15] | step_pulse;

endmodule
`default_nettype wire
